// File: rtl/sap_control_sequencer_if.sv
// Control bundle between the SAP sequencer and the datapath: mode/step,
// opcode and flags in; per-T-state control word, halt and T-state out.
interface sap_control_sequencer_if;
  logic       run;
  logic       step;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;
  logic       cp, lp, lm, li, la, lb, lo;
  logic       ep, ce, ei, ea, eu, su;
  logic       hlt;
  logic [5:0] tstate;

  modport master (
    output run, step, opcode, carry, zero,
    input  cp, lp, lm, li, la, lb, lo,
    input  ep, ce, ei, ea, eu, su,
    input  hlt, tstate
  );

  modport slave (
    input  run, step, opcode, carry, zero,
    output cp, lp, lm, li, la, lb, lo,
    output ep, ce, ei, ea, eu, su,
    output hlt, tstate
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP T-state ring sequencer and microcode decoder: one T-state per advance,
// control word combinational from current state; pauses and halts freeze the ring.
module sap_control_sequencer (
  input  logic                   clk,
  input  logic                   clr_n,
  sap_control_sequencer_if.slave bus
);

  localparam logic [6:0] L_CP = 7'b1000000;
  localparam logic [6:0] L_LP = 7'b0100000;
  localparam logic [6:0] L_LM = 7'b0010000;
  localparam logic [6:0] L_LI = 7'b0001000;
  localparam logic [6:0] L_LA = 7'b0000100;
  localparam logic [6:0] L_LB = 7'b0000010;
  localparam logic [6:0] L_LO = 7'b0000001;

  localparam logic [5:0] E_EP = 6'b100000;
  localparam logic [5:0] E_CE = 6'b010000;
  localparam logic [5:0] E_EI = 6'b001000;
  localparam logic [5:0] E_EA = 6'b000100;
  localparam logic [5:0] E_EU = 6'b000010;
  localparam logic [5:0] E_SU = 6'b000001;

  logic [5:0] r_tstate;
  logic       r_halt;
  logic       r_step_q;

  logic [5:0] w_tstate_nxt;
  logic       w_halt_nxt;
  logic       w_adv;
  logic       w_hlt_op;
  logic       w_gate;
  logic [6:0] w_ld_raw;
  logic [5:0] w_en_raw;
  logic [6:0] w_ld;
  logic [5:0] w_en;

  assign w_adv    = bus.run | (bus.step & ~r_step_q);
  assign w_hlt_op = r_tstate[3] & (bus.opcode == 4'b1111);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_tstate <= 6'b000001;
      r_halt   <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_tstate <= w_tstate_nxt;
      r_halt   <= w_halt_nxt;
      r_step_q <= bus.step;
    end
  end

  // HLT in T4 latches HALT instead of advancing, so the ring stays parked on T4.
  always_comb begin
    w_tstate_nxt = r_tstate;
    w_halt_nxt   = r_halt;
    if (!r_halt && w_adv) begin
      if (w_hlt_op) begin
        w_halt_nxt = 1'b1;
      end else begin
        w_tstate_nxt = {r_tstate[4:0], r_tstate[5]};
      end
    end
  end

  always_comb begin
    w_ld_raw = 7'b0;
    w_en_raw = 6'b0;
    case (r_tstate)
      6'b000001: begin w_en_raw = E_EP; w_ld_raw = L_LM; end
      6'b000010: begin w_ld_raw = L_CP; end
      6'b000100: begin w_en_raw = E_CE; w_ld_raw = L_LI; end
      6'b001000: begin
        case (bus.opcode)
          4'b0000, 4'b0001, 4'b0010: begin w_en_raw = E_EI; w_ld_raw = L_LM; end
          4'b0011: begin w_en_raw = E_EI; w_ld_raw = L_LA; end
          4'b0100: begin w_en_raw = E_EI; w_ld_raw = L_LP; end
          4'b0101: begin w_en_raw = E_EI; w_ld_raw = bus.carry ? L_LP : 7'b0; end
          4'b0110: begin w_en_raw = E_EI; w_ld_raw = bus.zero  ? L_LP : 7'b0; end
          4'b1110: begin w_en_raw = E_EA; w_ld_raw = L_LO; end
          default: begin end
        endcase
      end
      6'b010000: begin
        case (bus.opcode)
          4'b0000:          begin w_en_raw = E_CE; w_ld_raw = L_LA; end
          4'b0001, 4'b0010: begin w_en_raw = E_CE; w_ld_raw = L_LB; end
          default: begin end
        endcase
      end
      6'b100000: begin
        case (bus.opcode)
          4'b0001: begin w_en_raw = E_EU;        w_ld_raw = L_LA; end
          4'b0010: begin w_en_raw = E_EU | E_SU; w_ld_raw = L_LA; end
          default: begin end
        endcase
      end
      default: begin end
    endcase
  end

  // Loads/counts only fire on an advancing cycle; enables hold for the whole state.
  assign w_gate = clr_n & ~r_halt;
  assign w_ld   = w_ld_raw & {7{w_gate & w_adv}};
  assign w_en   = w_en_raw & {6{w_gate}};

  assign {bus.cp, bus.lp, bus.lm, bus.li, bus.la, bus.lb, bus.lo} = w_ld;
  assign {bus.ep, bus.ce, bus.ei, bus.ea, bus.eu, bus.su}         = w_en;
  assign bus.hlt    = clr_n & (r_halt | w_hlt_op);
  assign bus.tstate = r_tstate;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed table-driven bench for the SAP control sequencer.
module tb_sap_control_sequencer;

  localparam logic [13:0] CP = 14'h2000, LP = 14'h1000, LM = 14'h0800, LI = 14'h0400;
  localparam logic [13:0] LA = 14'h0200, LB = 14'h0100, LO = 14'h0080, EP = 14'h0040;
  localparam logic [13:0] CE = 14'h0020, EI = 14'h0010, EA = 14'h0008, EU = 14'h0004;
  localparam logic [13:0] SU = 14'h0002, HL = 14'h0001, NO = 14'h0000;

  typedef struct packed {
    logic        clr_n;
    logic        run;
    logic        step;
    logic [3:0]  op;
    logic        carry;
    logic        zero;
    logic [5:0]  ts;
    logic [13:0] ctl;
  } vec_t;

  logic clk;
  logic clr_n;
  sap_control_sequencer_if bus ();

  sap_control_sequencer dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] ctl;
  assign ctl = {bus.cp, bus.lp, bus.lm, bus.li, bus.la, bus.lb, bus.lo,
                bus.ep, bus.ce, bus.ei, bus.ea, bus.eu, bus.su, bus.hlt};

  vec_t vt[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int idx, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic r, input logic s, input logic [3:0] op,
                     input logic cy, input logic z, input logic [5:0] ts, input logic [13:0] ct);
    vec_t v;
    v = '{clr_n: c, run: r, step: s, op: op, carry: cy, zero: z, ts: ts, ctl: ct};
    vt.push_back(v);
  endtask

  task automatic add_instr(input logic [3:0] op, input logic cy, input logic z,
                           input logic [13:0] e4, input logic [13:0] e5, input logic [13:0] e6);
    add(1, 1, 0, op, cy, z, 6'h01, EP | LM);
    add(1, 1, 0, op, cy, z, 6'h02, CP);
    add(1, 1, 0, op, cy, z, 6'h04, CE | LI);
    add(1, 1, 0, op, cy, z, 6'h08, e4);
    add(1, 1, 0, op, cy, z, 6'h10, e5);
    add(1, 1, 0, op, cy, z, 6'h20, e6);
  endtask

  task automatic drive(input logic c, input logic r, input logic s, input logic [3:0] op,
                       input logic cy, input logic z);
    clr_n      = c;
    bus.run    = r;
    bus.step   = s;
    bus.opcode = op;
    bus.carry  = cy;
    bus.zero   = z;
  endtask

  initial begin
    int waited;
    drive(0, 0, 0, 4'h0, 0, 0);

    add_instr(4'h1, 0, 0, EI | LM, CE | LB, EU | LA);
    add_instr(4'h2, 0, 0, EI | LM, CE | LB, SU | EU | LA);
    add_instr(4'h0, 0, 0, EI | LM, CE | LA, NO);
    add_instr(4'h5, 1, 0, EI | LP, NO, NO);
    add_instr(4'h5, 0, 0, EI, NO, NO);
    add_instr(4'h6, 0, 1, EI | LP, NO, NO);
    add_instr(4'h6, 0, 0, EI, NO, NO);
    add_instr(4'h3, 0, 0, EI | LA, NO, NO);
    add_instr(4'h4, 0, 0, EI | LP, NO, NO);
    add_instr(4'hE, 0, 0, EA | LO, NO, NO);
    add_instr(4'hA, 1, 1, NO, NO, NO);
    // JC with carry raised only after T4
    add(1, 1, 0, 4'h5, 0, 0, 6'h01, EP | LM);
    add(1, 1, 0, 4'h5, 0, 0, 6'h02, CP);
    add(1, 1, 0, 4'h5, 0, 0, 6'h04, CE | LI);
    add(1, 1, 0, 4'h5, 0, 0, 6'h08, EI);
    add(1, 1, 0, 4'h5, 1, 0, 6'h10, NO);
    add(1, 1, 0, 4'h5, 1, 0, 6'h20, NO);
    // single step: high 5, low 3, high 1 -> two advances, cp only when advancing
    add(1, 0, 1, 4'h1, 0, 0, 6'h01, EP | LM);
    for (int k = 0; k < 4; k++) add(1, 0, 1, 4'h1, 0, 0, 6'h02, NO);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 4'h1, 0, 0, 6'h02, NO);
    add(1, 0, 1, 4'h1, 0, 0, 6'h02, CP);
    add(1, 0, 0, 4'h1, 0, 0, 6'h04, CE);
    // resume free-run into HLT; halted machine ignores run/step
    add(1, 1, 0, 4'hF, 0, 0, 6'h04, CE | LI);
    add(1, 1, 0, 4'hF, 0, 0, 6'h08, HL);
    add(1, 1, 0, 4'hF, 0, 0, 6'h08, HL);
    add(1, 0, 1, 4'hF, 0, 0, 6'h08, HL);
    add(1, 0, 0, 4'hF, 0, 0, 6'h08, HL);
    add(1, 1, 1, 4'hF, 0, 0, 6'h08, HL);
    add(0, 1, 0, 4'hF, 0, 0, 6'h08, NO);
    // ADD interrupted by reset in T5
    add(1, 1, 0, 4'h1, 0, 0, 6'h01, EP | LM);
    add(1, 1, 0, 4'h1, 0, 0, 6'h02, CP);
    add(1, 1, 0, 4'h1, 0, 0, 6'h04, CE | LI);
    add(1, 1, 0, 4'h1, 0, 0, 6'h08, EI | LM);
    add(0, 1, 0, 4'h1, 0, 0, 6'h10, NO);
    add(1, 1, 0, 4'h1, 0, 0, 6'h01, EP | LM);
    add(1, 1, 0, 4'h1, 0, 0, 6'h02, CP);
    // step held through reset release counts as an edge; then 0,1,0,1 toggles
    add(0, 0, 1, 4'h1, 0, 0, 6'h04, NO);
    add(1, 0, 1, 4'h1, 0, 0, 6'h01, EP | LM);
    add(1, 0, 1, 4'h1, 0, 0, 6'h02, NO);
    add(1, 0, 0, 4'h1, 0, 0, 6'h02, NO);
    add(1, 0, 1, 4'h1, 0, 0, 6'h02, CP);
    add(1, 0, 0, 4'h1, 0, 0, 6'h04, CE);
    add(1, 0, 1, 4'h1, 0, 0, 6'h04, CE | LI);

    // reset: two cycles low
    @(negedge clk);
    drive(0, 1, 0, 4'h0, 0, 0);
    @(negedge clk);
    #1;
    chk("rst_ts", 0, {8'h0, bus.tstate}, 14'h0001);
    chk("rst_ctl", 0, ctl, NO);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].clr_n, vt[i].run, vt[i].step, vt[i].op, vt[i].carry, vt[i].zero);
      #1;
      chk("ts", i, {8'h0, bus.tstate}, {8'h0, vt[i].ts});
      chk("ctl", i, ctl, vt[i].ctl);
    end

    // free-run from T4 of a step sequence into HLT, then hammer run/step
    @(negedge clk);
    drive(1, 1, 0, 4'hF, 0, 0);
    waited = 0;
    #1;
    while (!bus.hlt && waited < 12) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("hlt_wait", waited, {13'h0, bus.hlt}, 14'h0001);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      chk("halt_ts", k, {8'h0, bus.tstate}, 14'h0008);
      chk("halt_ctl", k, ctl, HL);
    end
    @(negedge clk);
    drive(0, 1, 0, 4'h0, 0, 0);
    #1;
    chk("clr_ctl", 0, ctl, NO);
    @(negedge clk);
    drive(1, 1, 0, 4'h0, 0, 0);
    #1;
    chk("clr_ts", 0, {8'h0, bus.tstate}, 14'h0001);
    chk("clr_ctl", 1, ctl, EP | LM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
